// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scanner with debounced press/release and one-shot key codes
module keypad_scanner #(
  parameter int SCAN_DIV     = 8,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    row_m_q, row_s_q, col_q, col_d, key_code_q, key_code_d, deb_q, deb_d;
  logic [1:0]    col_idx_q, col_idx_d, row_idx_q, row_idx_d, hit_idx;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic          sample, one_low, match, accept, rel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_m_q     <= 4'b1111;
      row_s_q     <= 4'b1111;
      state_q     <= SCAN;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_m_q     <= row;
      row_s_q     <= row_m_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  assign sample  = dwell_q == DW'(SCAN_DIV - 1);
  assign dwell_d = sample ? '0 : dwell_q + 1'b1;
  always_comb begin
    one_low = 1'b1;
    hit_idx = 2'd0;
    case (row_s_q)
      4'b1110: hit_idx = 2'd0;
      4'b1101: hit_idx = 2'd1;
      4'b1011: hit_idx = 2'd2;
      4'b0111: hit_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end
  assign match = one_low && hit_idx == row_idx_q;
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    accept    = 1'b0;
    rel       = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          state_d   = one_low ? DEBOUNCE : SCAN;
          deb_d     = one_low ? 4'd1 : deb_q;
          row_idx_d = one_low ? hit_idx : row_idx_q;
          col_idx_d = one_low ? col_idx_q : col_idx_q + 2'd1;
        end
        DEBOUNCE: begin
          state_d   = match ? DEBOUNCE : SCAN;
          deb_d     = match ? deb_q + 4'd1 : 4'd0;
          col_idx_d = match ? col_idx_q : col_idx_q + 2'd1;
        end
        HELD:    deb_d = row_s_q[row_idx_q] ? deb_q + 4'd1 : 4'd0;
        default: state_d = SCAN;
      endcase
      // DEBOUNCE_CNT==1 accepts straight out of SCAN because the check follows the case
      if (state_d == DEBOUNCE && deb_d == DEB) begin
        accept  = 1'b1;
        state_d = HELD;
        deb_d   = 4'd0;
      end else if (state_q == HELD && deb_d == DEB) begin
        rel       = 1'b1;
        state_d   = SCAN;
        deb_d     = 4'd0;
        col_idx_d = col_idx_q + 2'd1;
      end
    end
  end
  always_comb begin
    col_d       = ~(4'b0001 << col_idx_d);
    key_valid_d = accept;
    key_code_d  = accept ? {row_idx_d, col_idx_d} : key_code_q;
    key_held_d  = accept | (key_held_q & ~rel);
  end
  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
endmodule
